// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined MIPS decode/control carrying the ID/EX, EX/MEM, MEM/WB bundles
// with load-use and mult/div busy hazard stalls.
module ctrl_pipe #(
  parameter int ALUCTRL_W   = 4,
  parameter int MD_CYCLES   = 8,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          id_instr,
  input  logic                 id_valid,
  input  logic                 flush,
  output logic                 stall_id,
  output logic [ALUCTRL_W+8:0] ex_ctrl,
  output logic [4:0]           ex_wreg,
  output logic                 mem_memwrite,
  output logic                 mem_memread,
  output logic                 mem_regwrite,
  output logic                 mem_memtoreg,
  output logic [4:0]           mem_wreg,
  output logic                 wb_regwrite,
  output logic                 wb_memtoreg,
  output logic [4:0]           wb_wreg,
  output logic                 ex_illegal,
  output logic                 md_busy
);
  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_LUI = 4'd3, A_XOR = 4'd4, A_NOR = 4'd5;
  localparam logic [3:0] A_SUB = 4'd6, A_SLT = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10, A_SLTU = 4'd11;

  typedef struct packed {
    logic [3:0] alu;
    logic       alusrc, sign, branch, eq, jump, jr, link, memread, md_start;
    logic       memwrite, regwrite, memtoreg, illegal;
    logic [4:0] wreg;
  } ctl_t;

  typedef struct packed {
    logic       memwrite, memread, regwrite, memtoreg;
    logic [4:0] wreg;
  } mem_t;

  typedef struct packed {
    logic       regwrite, memtoreg;
    logic [4:0] wreg;
  } wb_t;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  ctl_t       dec, idex_d, idex_q;
  mem_t       exmem_d, exmem_q;
  wb_t        memwb_d, memwb_q;
  logic [7:0] md_d, md_q;
  logic       use_rs, use_rt, load_use, md_haz;

  assign {op, rs, rt, rd} = id_instr[31:11];
  assign fn = id_instr[5:0];

  always_comb begin
    dec = '0;
    case (op)
      6'h00: begin
        dec.regwrite = 1'b1;
        dec.wreg = rd;
        case (fn)
          6'h00, 6'h04: dec.alu = A_SLL;
          6'h02, 6'h06: dec.alu = A_SRL;
          6'h03, 6'h07: dec.alu = A_SRA;
          6'h20, 6'h21: dec.alu = A_ADD;
          6'h22, 6'h23: dec.alu = A_SUB;
          6'h24: dec.alu = A_AND;
          6'h25: dec.alu = A_OR;
          6'h26: dec.alu = A_XOR;
          6'h27: dec.alu = A_NOR;
          6'h2a: dec.alu = A_SLT;
          6'h2b: dec.alu = A_SLTU;
          6'h10, 6'h12: dec.alu = A_AND;
          6'h08: {dec.jr, dec.regwrite} = 2'b10;
          6'h18, 6'h19, 6'h1a, 6'h1b: {dec.md_start, dec.regwrite} = 2'b10;
          default: begin
            dec = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      6'h02: dec.jump = 1'b1;
      6'h03: begin
        {dec.jump, dec.link, dec.regwrite} = 3'b111;
        dec.wreg = 5'd31;
      end
      6'h04, 6'h05: begin
        {dec.branch, dec.sign, dec.alu} = {2'b11, A_SUB};
        dec.eq = op == 6'h04;
      end
      6'h08, 6'h0a: begin
        {dec.alusrc, dec.sign, dec.regwrite, dec.wreg} = {3'b111, rt};
        dec.alu = op == 6'h08 ? A_ADD : A_SLT;
      end
      6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        {dec.alusrc, dec.regwrite, dec.wreg} = {2'b11, rt};
        dec.alu = op == 6'h0c ? A_AND : op == 6'h0d ? A_OR : op == 6'h0e ? A_XOR : A_LUI;
      end
      6'h23: begin
        {dec.memread, dec.memtoreg, dec.regwrite, dec.alusrc, dec.sign} = 5'b11111;
        {dec.alu, dec.wreg} = {A_ADD, rt};
      end
      6'h2b: {dec.memwrite, dec.alusrc, dec.sign, dec.alu} = {3'b111, A_ADD};
      default: dec.illegal = 1'b1;
    endcase
    // $0 is never a real destination; non-writers carry wreg=0 so hazards ignore them
    dec.regwrite = dec.regwrite && dec.wreg != 5'd0;
    dec.wreg = dec.regwrite ? dec.wreg : 5'd0;
  end

  assign use_rs   = !(op == 6'h02 || op == 6'h03 || op == 6'h0f ||
                      (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)));
  assign use_rt   = op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b;
  assign load_use = LOAD_USE_EN && idex_q.memread && idex_q.wreg != 5'd0 &&
                    ((use_rs && rs == idex_q.wreg) || (use_rt && rt == idex_q.wreg));
  assign md_haz   = md_busy && op == 6'h00 && (fn == 6'h10 || fn == 6'h12 || fn[5:2] == 4'b0110);
  assign stall_id = id_valid && (load_use || md_haz) && !flush;
  assign md_busy  = md_q != 8'd0;

  always_comb begin
    idex_d  = (flush || stall_id || !id_valid) ? '0 : dec;
    exmem_d = '{memwrite: idex_q.memwrite, memread: idex_q.memread, regwrite: idex_q.regwrite,
                memtoreg: idex_q.memtoreg, wreg: idex_q.wreg};
    memwb_d = '{regwrite: exmem_q.regwrite, memtoreg: exmem_q.memtoreg, wreg: exmem_q.wreg};
    md_d    = idex_d.md_start ? 8'(MD_CYCLES) : md_q - {7'd0, md_busy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      md_q    <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      md_q    <= md_d;
    end
  end

  assign ex_ctrl = {ALUCTRL_W'(idex_q.alu), idex_q.alusrc, idex_q.sign, idex_q.branch, idex_q.eq,
                    idex_q.jump, idex_q.jr, idex_q.link, idex_q.memread, idex_q.md_start};
  assign ex_wreg    = idex_q.wreg;
  assign ex_illegal = idex_q.illegal;
  assign {mem_memwrite, mem_memread, mem_regwrite, mem_memtoreg, mem_wreg} = exmem_q;
  assign {wb_regwrite, wb_memtoreg, wb_wreg} = memwb_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed hazard/decode scenarios then random instruction stream,
// checked every cycle against a history-queue model of the pipeline.
module tb_ctrl_pipe;
  localparam int W  = 4;
  localparam int MD = 8;

  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, flush = 1'b0;
  logic [31:0] id_instr = '0;
  logic stall_id, mem_memwrite, mem_memread, mem_regwrite, mem_memtoreg;
  logic wb_regwrite, wb_memtoreg, ex_illegal, md_busy;
  logic [W+8:0] ex_ctrl;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic n_stall, n_mw, n_mr, n_mrw, n_mtr, n_wrw, n_wtr, n_ill, n_busy;
  logic [W+8:0] n_ctrl;
  logic [4:0] n_exw, n_memw, n_wbw;

  ctrl_pipe #(.ALUCTRL_W(W), .MD_CYCLES(MD), .LOAD_USE_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall_id(stall_id), .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_wreg(wb_wreg), .ex_illegal(ex_illegal), .md_busy(md_busy));

  ctrl_pipe #(.ALUCTRL_W(W), .MD_CYCLES(MD), .LOAD_USE_EN(1'b0)) u_nlu (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall_id(n_stall), .ex_ctrl(n_ctrl), .ex_wreg(n_exw),
    .mem_memwrite(n_mw), .mem_memread(n_mr), .mem_regwrite(n_mrw),
    .mem_memtoreg(n_mtr), .mem_wreg(n_memw), .wb_regwrite(n_wrw),
    .wb_memtoreg(n_wtr), .wb_wreg(n_wbw), .ex_illegal(n_ill), .md_busy(n_busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic       alusrc, sign, branch, eq, jump, jr, link, memread, md_start;
    logic       memwrite, regwrite, memtoreg, illegal;
    logic [4:0] wreg;
  } ent_t;

  localparam logic [5:0] RFN [0:24] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
    6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h18, 6'h19, 6'h1a, 6'h1b,
    6'h10, 6'h12, 6'h3f, 6'h01};
  localparam logic [5:0] IOP [0:13] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d,
    6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h09, 6'h3f};

  ent_t hist[$];
  ent_t cx, cm, cw;
  int   edge_n = 0, md_end = 0, n_cmp = 0, n_err = 0, nst, nb;
  bit   chk = 1'b0, last_stall = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return 2;
      6'h22, 6'h23: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h26: return 4;
      6'h27: return 5;
      6'h2a: return 7;
      6'h2b: return 11;
      6'h00, 6'h04: return 8;
      6'h02, 6'h06: return 9;
      6'h03, 6'h07: return 10;
      default: return -1;
    endcase
  endfunction

  function automatic ent_t ref_dec(input logic [31:0] ins);
    ent_t e;
    int a;
    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    op = ins[31:26]; fn = ins[5:0]; rt = ins[20:16]; rd = ins[15:11];
    e = '0;
    a = r_alu(fn);
    if (op == 6'h00) begin
      if (a >= 0) begin e.alu = a[3:0]; e.regwrite = 1'b1; e.wreg = rd; end
      else if (fn == 6'h08) e.jr = 1'b1;
      else if (fn >= 6'h18 && fn <= 6'h1b) e.md_start = 1'b1;
      else if (fn == 6'h10 || fn == 6'h12) begin e.regwrite = 1'b1; e.wreg = rd; end
      else e.illegal = 1'b1;
    end else begin
      case (op)
        6'h02: e.jump = 1'b1;
        6'h03: begin e.jump = 1'b1; e.link = 1'b1; e.regwrite = 1'b1; e.wreg = 5'd31; end
        6'h04: begin e.branch = 1'b1; e.eq = 1'b1; e.sign = 1'b1; e.alu = 4'd6; end
        6'h05: begin e.branch = 1'b1; e.sign = 1'b1; e.alu = 4'd6; end
        6'h08: begin e.alusrc = 1'b1; e.sign = 1'b1; e.regwrite = 1'b1; e.wreg = rt; e.alu = 4'd2; end
        6'h0a: begin e.alusrc = 1'b1; e.sign = 1'b1; e.regwrite = 1'b1; e.wreg = rt; e.alu = 4'd7; end
        6'h0c: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.wreg = rt; e.alu = 4'd0; end
        6'h0d: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.wreg = rt; e.alu = 4'd1; end
        6'h0e: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.wreg = rt; e.alu = 4'd4; end
        6'h0f: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.wreg = rt; e.alu = 4'd3; end
        6'h23: begin e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; e.alusrc = 1'b1;
                     e.sign = 1'b1; e.alu = 4'd2; e.wreg = rt; end
        6'h2b: begin e.memwrite = 1'b1; e.alusrc = 1'b1; e.sign = 1'b1; e.alu = 4'd2; end
        default: e.illegal = 1'b1;
      endcase
    end
    if (e.wreg == 5'd0) e.regwrite = 1'b0;
    if (!e.regwrite) e.wreg = 5'd0;
    return e;
  endfunction

  function automatic bit exp_stall();
    ent_t x;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    bit urs, urt, lu, mdh;
    x = hist[2];
    op = id_instr[31:26]; fn = id_instr[5:0]; rs = id_instr[25:21]; rt = id_instr[20:16];
    urs = !(op == 6'h02 || op == 6'h03 || op == 6'h0f || (op == 6'h00 && fn inside {6'h00, 6'h02, 6'h03}));
    urt = op inside {6'h00, 6'h04, 6'h05, 6'h2b};
    lu  = x.memread && x.wreg != 5'd0 && ((urs && rs == x.wreg) || (urt && rt == x.wreg));
    mdh = edge_n < md_end && op == 6'h00 && fn inside {6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b};
    return id_valid && !flush && (lu || mdh);
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    md_end = edge_n;
  endtask

  task automatic adv();
    ent_t e;
    bit st;
    st = exp_stall();
    e = (flush || st || !id_valid) ? ent_t'(0) : ref_dec(id_instr);
    last_stall = st;
    edge_n++;
    if (e.md_start) md_end = edge_n + MD;
    hist.push_back(e);
    void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    adv();
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic f);
    id_instr = ins; id_valid = v; flush = f;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); c = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) return enc_r(RFN[$urandom_range(0, 24)], a, b, c);
    return enc_i(IOP[$urandom_range(0, 13)], a, b, 16'($urandom));
  endfunction

  always @(negedge clk) begin
    if (chk && rst_n) begin
      cx = hist[2]; cm = hist[1]; cw = hist[0];
      check("stall_id", 32'(stall_id), 32'(exp_stall()));
      check("ex_ctrl", 32'(ex_ctrl), 32'({cx.alu, cx.alusrc, cx.sign, cx.branch, cx.eq, cx.jump,
                                          cx.jr, cx.link, cx.memread, cx.md_start}));
      check("ex_wreg", 32'(ex_wreg), 32'(cx.wreg));
      check("ex_illegal", 32'(ex_illegal), 32'(cx.illegal));
      check("md_busy", 32'(md_busy), 32'(edge_n < md_end));
      check("mem_stage", 32'({mem_memwrite, mem_memread, mem_regwrite, mem_memtoreg, mem_wreg}),
                         32'({cm.memwrite, cm.memread, cm.regwrite, cm.memtoreg, cm.wreg}));
      check("wb_stage", 32'({wb_regwrite, wb_memtoreg, wb_wreg}), 32'({cw.regwrite, cw.memtoreg, cw.wreg}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] lw8, add9, mult12, mfhi3;
    lw8 = enc_i(6'h23, 5'd1, 5'd8, 16'd0);
    add9 = enc_r(6'h20, 5'd8, 5'd2, 5'd9);
    mult12 = enc_r(6'h18, 5'd1, 5'd2, 5'd0);
    mfhi3 = enc_r(6'h10, 5'd0, 5'd0, 5'd3);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_stall", 32'(stall_id), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    check("rst_wb", 32'({wb_regwrite, wb_memtoreg, wb_wreg}), 32'd0);
    rst_n = 1'b1;
    chk = 1'b1;

    drive(lw8, 1'b1, 1'b0); tick();
    drive(add9, 1'b1, 1'b0); #1;
    check("lu_stall", 32'(stall_id), 32'd1);
    check("nolu_stall", 32'(n_stall), 32'd0);
    tick();
    check("lu_bubble", 32'(ex_ctrl), 32'd0);
    #1;
    check("lu_release", 32'(stall_id), 32'd0);
    tick();
    check("lu_add_alu", 32'(ex_ctrl[W+8:9]), 32'd2);
    check("lu_add_wreg", 32'(ex_wreg), 32'd9);

    drive(enc_i(6'h23, 5'd1, 5'd0, 16'd4), 1'b1, 1'b0); tick();
    drive(enc_r(6'h20, 5'd0, 5'd2, 5'd9), 1'b1, 1'b0); #1;
    check("lw0_nostall", 32'(stall_id), 32'd0);
    tick();
    drive(lw8, 1'b1, 1'b0); tick();
    drive(enc_i(6'h02, 5'd8, 5'd8, 16'd8), 1'b1, 1'b0); #1;
    check("lw_j_nostall", 32'(stall_id), 32'd0);
    tick();

    drive(mult12, 1'b1, 1'b0); tick();
    drive(mfhi3, 1'b1, 1'b0);
    nst = 0; nb = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (md_busy) nb++;
      if (!stall_id) break;
      nst++;
      tick();
    end
    check("md_stall_cycles", 32'(nst), 32'(MD));
    check("md_busy_cycles", 32'(nb), 32'(MD));
    tick();
    check("mfhi_wreg", 32'(ex_wreg), 32'd3);
    check("mfhi_ctrl", 32'(ex_ctrl), 32'd0);
    drive('0, 1'b0, 1'b0); tick();
    check("mfhi_regwrite", 32'({mem_regwrite, mem_wreg}), 32'({1'b1, 5'd3}));

    drive(lw8, 1'b1, 1'b0); tick();
    drive(add9, 1'b1, 1'b1); #1;
    check("flush_nostall", 32'(stall_id), 32'd0);
    tick();
    check("flush_bubble", 32'({ex_ctrl, ex_wreg}), 32'd0);
    drive(mult12, 1'b1, 1'b1); tick();
    check("flush_mult", 32'(md_busy), 32'd0);

    drive(enc_i(6'h04, 5'd1, 5'd2, 16'd3), 1'b1, 1'b0); tick();
    check("beq_ctrl", 32'(ex_ctrl), 32'd3296);
    drive(enc_i(6'h05, 5'd1, 5'd2, 16'd3), 1'b1, 1'b0); tick();
    check("bne_ctrl", 32'(ex_ctrl), 32'd3264);
    drive(32'h0c00_0010, 1'b1, 1'b0); tick();
    check("jal_ctrl", 32'(ex_ctrl), 32'h14);
    check("jal_wreg", 32'(ex_wreg), 32'd31);
    drive(32'hfc00_0000, 1'b1, 1'b0); tick();
    check("ill_flag", 32'(ex_illegal), 32'd1);
    check("ill_ctrl", 32'(ex_ctrl), 32'd0);
    drive('0, 1'b0, 1'b0); tick();
    check("ill_mem_we", 32'({mem_regwrite, mem_memwrite}), 32'd0);
    check("jal_wb", 32'({wb_regwrite, wb_wreg}), 32'({1'b1, 5'd31}));

    drive(mult12, 1'b1, 1'b0); tick();
    drive(lw8, 1'b1, 1'b0); tick();
    chk = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_ex", 32'({ex_ctrl, ex_wreg}), 32'd0);
    check("arst_md_busy", 32'(md_busy), 32'd0);
    check("arst_mem", 32'({mem_memread, mem_regwrite, mem_wreg}), 32'd0);
    drive('0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk = 1'b1;
    drive(enc_r(6'h20, 5'd1, 5'd2, 5'd9), 1'b1, 1'b0); tick();
    check("arst_add_alu", 32'(ex_ctrl[W+8:9]), 32'd2);
    check("arst_add_wreg", 32'(ex_wreg), 32'd9);

    last_stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!last_stall) begin
        id_instr = rnd_instr();
        id_valid = $urandom_range(0, 9) != 0;
      end
      flush = $urandom_range(0, 11) == 0;
      tick();
    end
    chk = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Pipelined successor to the single-cycle decode controller. Decodes the ID-stage MIPS instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. Also detects hazards: load-use, and mult/div busy with its HI/LO readers. Drives the stall and flush behaviour of the 5-stage datapath.

Parameters:
ALUCTRL_W, 4, alucontrol width; must be >=4; codes below are zero-extended.
MD_CYCLES, 8, mult/div occupancy in cycles (1..255).
LOAD_USE_EN, 1, 1 enables load-use stall detection; 0 disables it (forwarding-only builds).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_instr  in  32  instruction in ID
id_valid  in  1  id_instr is a real instruction
flush  in  1  redirect from EX (branch taken/jump); kill ID instruction
stall_id  out  1  hold PC and IF/ID this cycle (combinational)
ex_ctrl  out  ALUCTRL_W+9  ID/EX bundle {alucontrol, alusrc, sign, branch, eq, jump, jr, link, memread, md_start}
ex_wreg  out  5  ID/EX destination register
mem_memwrite, mem_memread  out  1 each  EX/MEM stage
mem_regwrite, mem_memtoreg  out  1 each  EX/MEM stage
mem_wreg  out  5  EX/MEM destination
wb_regwrite, wb_memtoreg  out  1 each  MEM/WB stage
wb_wreg  out  5  MEM/WB destination
ex_illegal  out  1  ID/EX holds an undecodable opcode/funct
md_busy  out  1  mult/div counter nonzero

Behaviour:
- Reset (async, rst_n=0): all pipeline registers hold the bubble; md counter = 0. Every output is 0 (stall_id=0).
- Bubble = all control bits 0, wreg=0, illegal=0.
- Decode (combinational, ID):
  - R-type (op 0): regwrite=1, regdst → wreg=rd.
  - lw: memread, memtoreg, regwrite, alusrc, sign, ADD, wreg=rt.
  - sw: memwrite, alusrc, sign, ADD.
  - beq/bne: branch, SUB, sign; eq=1 for beq only.
  - addi/slti: alusrc, sign, regwrite, wreg=rt.
  - andi/ori/xori: alusrc, sign=0, regwrite, wreg=rt.
  - lui: LUI code.
  - j: jump.
  - jal: jump, link, regwrite, wreg=31.
  - jr (funct 08): jr=1, regwrite=0.
  - mult/multu/div/divu (18–1B): md_start=1, regwrite=0.
  - mfhi/mflo (10/12): regwrite, wreg=rd.
  - Anything else: bubble with illegal=1.
- ALU codes: AND=0, OR=1, ADD=2, LUI=3, XOR=4, NOR=5, SUB=6, SLT=7, SLL=8, SRL=9, SRA=10, SLTU=11.
- Any regwrite with wreg=0 has regwrite forced to 0.
- Hazards (combinational, only when id_valid=1):
  - Sources: rs for all but j/jal/lui/shift-immediate. rt for R-type, beq, bne, sw.
  - load_use = LOAD_USE_EN & ex memread & ex_wreg≠0 & ex_wreg matches a used source.
  - md_haz = md_busy & ID is mfhi/mflo/mult/div.
  - stall_id = (load_use | md_haz) & ~flush.
- ID/EX update each edge, by priority:
  - flush → bubble.
  - stall_id → bubble; ID instruction is re-presented next cycle.
  - !id_valid → bubble.
  - Otherwise → decoded bundle.
- EX/MEM and MEM/WB always advance. Each copies its subset from the previous stage; no stall freezes them. Latency ID→EX = 1 cycle, →MEM = 2, →WB = 3.
- md counter:
  - Loads MD_CYCLES when a md_start instruction enters ID/EX.
  - Otherwise decrements to 0 and saturates there.
  - A flushed mult/div never loads the counter.
- Simultaneous flush+stall: flush wins and stall_id=0.
- Reset mid-operation: immediate bubble in all stages; any in-flight busy count is dropped.

Test Plan:
- Reset: rst_n=0 mid-stream with lw in EX → all outputs 0 asynchronously; after release, first add reaches ex_ctrl one edge later.
- Load-use: lw $8,0($1) then add $9,$8,$2 → stall_id=1 for one cycle, one bubble in EX. Next cycle add enters EX with alucontrol=2, ex_wreg=9. Repeat with LOAD_USE_EN=0 → no stall.
- No false stall: lw $0 then add $9,$0,$2 → stall_id=0. lw $8 then j → stall_id=0.
- Mult/div: mult $1,$2 then mfhi $3, MD_CYCLES=8 → md_busy high 8 cycles. mfhi is stalled until md_busy=0, then ex_wreg=3, regwrite=1.
- Flush priority: flush=1 together with load-use condition → stall_id=0, ID/EX bubble. A flushed mult leaves md_busy=0.
- Decode sweep: jal → jump=1, link=1, wb_wreg=31 three cycles later. beq/bne → eq 1/0. op 0x3F → ex_illegal=1 with all write enables 0.
